// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: op encodings, FSM states,
// and the fixed results returned for divide-by-zero and signed overflow.
package seq_alu_pkg;

  // {m, alt, funct3}
  typedef enum logic [4:0] {
    OP_ADD    = 5'b0_0_000,
    OP_SLL    = 5'b0_0_001,
    OP_SLT    = 5'b0_0_010,
    OP_SLTU   = 5'b0_0_011,
    OP_XOR    = 5'b0_0_100,
    OP_SRL    = 5'b0_0_101,
    OP_OR     = 5'b0_0_110,
    OP_AND    = 5'b0_0_111,
    OP_SUB    = 5'b0_1_000,
    OP_SRA    = 5'b0_1_101,
    OP_MUL    = 5'b1_0_000,
    OP_MULH   = 5'b1_0_001,
    OP_MULHSU = 5'b1_0_010,
    OP_MULHU  = 5'b1_0_011,
    OP_DIV    = 5'b1_0_100,
    OP_DIVU   = 5'b1_0_101,
    OP_REM    = 5'b1_0_110,
    OP_REMU   = 5'b1_0_111
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Replicated across XLEN: quotient on x/0 is all ones, remainder of MIN/-1 is zero.
  localparam logic DIV0_QUOT_FILL = 1'b1;
  localparam logic OVF_REM_FILL   = 1'b0;

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle on operand magnitudes. Only instantiated when SEQ_ALU_MDU_EN is defined.
module seq_alu_mdu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic            busy, is_div, hi_sel, rem_sel, neg_res, div_zero, ovf;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] p, p_next, prod;
  logic [XLEN-1:0] d, a_mag, b_mag, q_mag;
  logic            a_sgn, b_sgn;
  logic [XLEN:0]   sum, rem_sh, diff;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = src1[XLEN-1]; b_sgn = src2[XLEN-1]; end
      3'b010:                 a_sgn = src1[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? -src1 : src1;
    b_mag = b_sgn ? -src2 : src2;
  end

  // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum    = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, d} : '0);
    rem_sh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff   = rem_sh - {1'b0, d};
    if (!is_div)
      p_next = {sum, p[XLEN-1:1]};
    else if (rem_sh >= {1'b0, d})
      p_next = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else
      p_next = {rem_sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod  = neg_res ? -p_next : p_next;
    q_mag = rem_sel ? p_next[2*XLEN-1:XLEN] : p_next[XLEN-1:0];
    if (!is_div)
      result = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (div_zero)
      result = rem_sel ? d : {XLEN{DIV0_QUOT_FILL}};
    else if (ovf && rem_sel)
      result = {XLEN{OVF_REM_FILL}};
    else
      result = neg_res ? -q_mag : q_mag;
  end

  assign done = busy && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0; cnt <= '0; p <= '0; d <= '0;
      is_div <= 1'b0; hi_sel <= 1'b0; rem_sel <= 1'b0;
      neg_res <= 1'b0; div_zero <= 1'b0; ovf <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      is_div   <= funct3[2];
      hi_sel   <= funct3[1:0] != 2'b00;
      rem_sel  <= funct3[1];
      neg_res  <= (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
      div_zero <= funct3[2] && (src2 == '0);
      ovf      <= funct3[2] && !funct3[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
      p        <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
      // On x/0 the divisor is known to be zero, so d keeps the dividend for the remainder.
      d        <= funct3[2] ? ((src2 == '0) ? src1 : b_mag) : a_mag;
    end else if (busy) begin
      p   <= p_next;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: single-cycle base ops, iterative M ops when SEQ_ALU_MDU_EN
// is defined (otherwise every m=1 op reports illegal in one cycle).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);

  state_e          state;
  logic            accept, base_ill, m_op, mdu_done;
  logic [XLEN-1:0] base_res, mdu_res;
  logic [SW-1:0]   shamt;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = src2[SW-1:0];

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    m_op     = 1'b0;
    case (op)
      OP_ADD:  base_res = src1 + src2;
      OP_SUB:  base_res = src1 - src2;
      OP_SLL:  base_res = src1 << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_XOR:  base_res = src1 ^ src2;
      OP_SRL:  base_res = src1 >> shamt;
      OP_SRA:  base_res = $signed(src1) >>> shamt;
      OP_OR:   base_res = src1 | src2;
      OP_AND:  base_res = src1 & src2;
`ifdef SEQ_ALU_MDU_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: m_op = 1'b1;
`endif
      default: base_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MDU_EN
  seq_alu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && m_op),
    .funct3 (op[2:0]),
    .src1   (src1),
    .src2   (src2),
    .done   (mdu_done),
    .result (mdu_res)
  );
`else
  assign mdu_done = 1'b0;
  assign mdu_res  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          // A new accept in DONE overrides the drain to IDLE above.
          if (accept) begin
            if (m_op) begin
              state     <= CALC;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= base_res;
              zero      <= (base_res == '0);
              illegal   <= base_ill;
            end
          end
        end
        CALC: if (mdu_done) begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= mdu_res;
          zero      <= (mdu_res == '0);
          illegal   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, monitor pops on handshake.
module tb_seq_alu;
  import seq_alu_pkg::*;
  localparam int XLEN = 32;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, illegal;
  logic [4:0] op = '0;
  logic [XLEN-1:0] src1 = '0, src2 = '0, result;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic ill; int rise; bit hold; } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0, hold_left = 0;
  bit seen = 1'b0, rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour in plain 64-bit arithmetic.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint sa = $signed(a);
    longint sbv = $signed(b);
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] pr;
    r = '0; ill = 1'b0; lat = 1;
    case (o)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[4:0];
      5'b00010: r = {31'b0, sa < sbv};
      5'b00011: r = {31'b0, a < b};
      5'b00100: r = a ^ b;
      5'b00101: r = a >> b[4:0];
      5'b01101: r = 32'(sa >>> b[4:0]);
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      default: begin
        ill = 1'b1;
`ifdef SEQ_ALU_MDU_EN
        if (o[4:3] == 2'b10) begin
          ill = 1'b0; lat = XLEN + 1;
          case (o[2:0])
            3'd0: begin pr = ua * ub; r = pr[31:0]; end
            3'd1: begin pr = sa * sbv; r = pr[63:32]; end
            3'd2: begin pr = sa * longint'(ub); r = pr[63:32]; end
            3'd3: begin pr = ua * ub; r = pr[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sbv);
            default: r = (b == 0) ? a : a % b;
          endcase
        end
`endif
      end
    endcase
  endfunction

  // Called aligned to posedge+1; returns the acceptance edge number.
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit hold, output int acc);
    exp_t e;
    int lat;
    int t = 0;
    op = o; src1 = a; src2 = b; in_valid = 1'b1; acc = -1;
    do begin @(negedge clk); t++; end while (!in_ready && t < 300);
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance of op %b", o);
    end else begin
      model(o, a, b, e.res, e.ill, lat);
      acc = cyc + 1;
      e.rise = acc + lat - 1;  // registered on the edge before it is sampled
      e.hold = hold;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 3000) begin @(negedge clk); t++; end
    if (sb.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete(); seen = 1'b0; hold_left = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (hold_left == 0 && out_valid && sb.size() > 0 && sb[0].hold) begin
      hold_left = 3;
      sb[0].hold = 1'b0;
    end
    if (hold_left > 0) begin out_ready = 1'b0; hold_left--; end
    else out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_valid: got result %0h expected no output", result);
      end else begin
        if (!seen) begin chk("latency", cyc, sb[0].rise); seen = 1'b1; end
        chk("result", result, sb[0].res);
        chk("illegal", illegal, sb[0].ill);
        chk("zero", zero, sb[0].res == 0);
        if (!out_ready) chk("in_ready_stall", in_ready, 0);
        else begin void'(sb.pop_front()); seen = 1'b0; end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc, prev;
    logic [2:0] f;
    logic [4:0] o;
    repeat (2) @(posedge clk);
    do_reset();

    send(OP_ADD,   32'h7FFF_FFFF, 32'h1, 1'b0, acc);
    send(OP_SUB,   32'd5, 32'd5, 1'b0, acc);
    send(OP_SRA,   32'h8000_0000, 32'd4, 1'b0, acc);
    send(5'b01001, 32'd3, 32'd4, 1'b0, acc);
    send(OP_DIV,   32'd7, 32'd0, 1'b0, acc);
    send(OP_REM,   32'd7, 32'd0, 1'b0, acc);
    send(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
    send(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
    send(OP_MUL,   32'd3, 32'hFFFF_FFFB, 1'b0, acc);
    drain();

    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(OP_ADD, $urandom, $urandom, 1'b0, acc);
      if (i > 0) chk("stream_gap", acc, prev + 1);
      prev = acc;
    end
    drain();

`ifdef SEQ_ALU_MDU_EN
    send(OP_DIV, 32'd100, 32'd7, 1'b0, acc);
    repeat (10) @(posedge clk);
    #1;
`endif
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    send(OP_ADD, 32'd1, 32'd2, 1'b0, acc);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 5))
        0, 1: o = {2'b10, f};
        2:    o = {2'b01, f};
        default: o = {2'b00, f};
      endcase
      send(o, pick(), pick(), 1'b0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
